rand_sched: RTL and testbench

Round-robin scheduler sharing the game's 2-bit-per-cycle random source (`rand_gen`) among several consumers: bomber drift, bomb drop timing and colour selection. A granted requester receives a WIDTH-bit random word. The word is assembled by shifting in `rand_in` for WIDTH/2 cycles, so no two consumers ever see overlapping bits. The block sits between `rand_gen` and the game-logic FSMs.

---
 rtl/rand_sched_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/rand_sched.sv | 139 +++++++++++++
 tb/tb_rand_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_sched_pkg.sv
// Shared types and constants for the rand_sched random-word scheduler.
// The CHECK state is only reachable when RAND_REJECT_EN is defined.
package rand_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        CHECK   = 2'd2,
        DELIVER = 2'd3
    } state_t;

    localparam int                     REJ_CNT_W   = 8;
    localparam logic [REJ_CNT_W-1:0]   REJ_CNT_MAX = 8'd255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first set request bit strictly
// after ptr (wrapping past NREQ-1 to 0) wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    logic [PW-1:0] idx;

    // Scan from the farthest offset down to ptr+1 so the nearest request is the one that sticks.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rand_sched.sv
// Round-robin scheduler handing out WIDTH-bit random words assembled from the
// 2-bit-per-cycle rand_gen stream. Each word uses bits nobody else sees.
// Optional feature: define RAND_REJECT_EN to add rejection sampling so words
// are uniform in [0, LIMIT); this also adds the reject_cnt port.
module rand_sched
    import rand_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LIMIT = 160
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           rand_in,
    input  logic [NREQ-1:0]      req,
    output logic                 rand_valid,
    output logic [NREQ-1:0]      rand_gnt,
    output logic [WIDTH-1:0]     rand_data,
    output logic                 busy
`ifdef RAND_REJECT_EN
    ,
    output logic [REJ_CNT_W-1:0] reject_cnt
`endif
);

    localparam int             PW   = $clog2(NREQ);
    localparam int             HALF = WIDTH / 2;
    localparam int             CW   = $clog2(HALF + 1);
    localparam logic [CW-1:0]  LAST = CW'(HALF - 1);

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  acc;
    logic [PW-1:0]     pick_win;
    logic              pick_any;

`ifdef RAND_REJECT_EN
    localparam logic [WIDTH:0] LIM_V = (WIDTH + 1)'(LIMIT);

    function automatic logic [REJ_CNT_W-1:0] sat_inc(input logic [REJ_CNT_W-1:0] v);
        return (v == REJ_CNT_MAX) ? v : v + 1'b1;
    endfunction
`endif

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_win),
        .any    (pick_any)
    );

    // Accumulator: cleared while idle, shifts in two fresh bits each FILL cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            acc <= '0;
        end else if (state == FILL) begin
            acc <= WIDTH'({acc, rand_in});
        end
    end

    // Scheduler FSM with all outputs registered; the winner is locked in at IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= PW'(NREQ - 1);
            win        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            rand_valid <= 1'b0;
            rand_gnt   <= '0;
            rand_data  <= '0;
`ifdef RAND_REJECT_EN
            reject_cnt <= '0;
`endif
        end else begin
            rand_valid <= 1'b0;
            rand_gnt   <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        win   <= pick_win;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (!req[win]) begin
                        // Winner withdrew: drop the partial word, keep ptr.
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
`ifdef RAND_REJECT_EN
                            state <= CHECK;
`else
                            state <= DELIVER;
`endif
                        end
                    end
                end
`ifdef RAND_REJECT_EN
                CHECK: begin
                    if (!req[win]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if ({1'b0, acc} < LIM_V) begin
                        state <= DELIVER;
                    end else begin
                        // Out of range: draw a completely fresh word.
                        cnt        <= '0;
                        reject_cnt <= sat_inc(reject_cnt);
                        state      <= FILL;
                    end
                end
`endif
                DELIVER: begin
                    rand_valid <= 1'b1;
                    rand_gnt   <= NREQ'(1) << win;
                    rand_data  <= acc;
                    ptr        <= win;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_sched.sv
// Testbench for rand_sched (NREQ=4, WIDTH=8, LIMIT=160). Works in both the
// default build and with RAND_REJECT_EN defined.
module tb_rand_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LIMIT = 160;
    localparam int HALF  = WIDTH / 2;
`ifdef RAND_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif
    localparam int DLV = REJ ? HALF + 2 : HALF + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       rand_in;
    logic [NREQ-1:0]  req;
    logic             rand_valid;
    logic [NREQ-1:0]  rand_gnt;
    logic [WIDTH-1:0] rand_data;
    logic             busy;
`ifdef RAND_REJECT_EN
    logic [7:0]       reject_cnt;
`endif

    rand_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rand_in    (rand_in),
        .req        (req),
        .rand_valid (rand_valid),
        .rand_gnt   (rand_gnt),
        .rand_data  (rand_data),
        .busy       (busy)
`ifdef RAND_REJECT_EN
        ,
        .reject_cnt (reject_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // ---------------- behavioural reference model ----------------
    bit         m_act;
    int         m_base, m_win, m_ptr, m_rej, m_cyc;
    logic [7:0] m_word, m_data;
    logic       e_valid, e_busy;
    logic [3:0] e_gnt;

    function automatic int rr_search(input logic [3:0] r, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    // Outcome of one clock edge given the inputs sampled on it.
    task automatic model_edge(input logic [3:0] r, input logic [1:0] x, input logic rs);
        int d;
        m_cyc++;
        e_valid = 1'b0;
        e_gnt   = 4'b0;
        if (rs) begin
            m_act = 1'b0; m_ptr = NREQ - 1; m_data = 8'h00; m_rej = 0;
        end else if (!m_act) begin
            if (r != 4'b0) begin
                m_win = rr_search(r, m_ptr); m_act = 1'b1; m_base = m_cyc; m_word = 8'h00;
            end
        end else begin
            d = m_cyc - m_base;
            if (d <= HALF) begin
                if (!r[m_win]) m_act = 1'b0;
                else m_word = {m_word[5:0], x};
            end else if (d < DLV) begin
                if (!r[m_win]) m_act = 1'b0;
                else if (int'(m_word) >= LIMIT) begin
                    m_base = m_cyc; m_word = 8'h00;
                    if (m_rej < 255) m_rej++;
                end
            end else begin
                e_valid = 1'b1; e_gnt = 4'(1) << m_win;
                m_data = m_word; m_ptr = m_win; m_act = 1'b0;
            end
        end
        e_busy = m_act;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic [1:0] x, input logic rs);
        logic [7:0] rc_act, rc_exp;
        req = r; rand_in = x; rst = rs;
        @(posedge clk);
        model_edge(r, x, rs);
        #1;
`ifdef RAND_REJECT_EN
        rc_act = reject_cnt; rc_exp = 8'(m_rej);
`else
        rc_act = 8'h00; rc_exp = 8'h00;
`endif
        vectors++;
        if (rand_valid !== e_valid || rand_gnt !== e_gnt || rand_data !== m_data ||
            busy !== e_busy || rc_act !== rc_exp) begin
            miscompares++;
            $display("FAIL model cyc%0d: valid %b/%b gnt %b/%b data %h/%h busy %b/%b rej %0d/%0d (got/expected)",
                     m_cyc, rand_valid, e_valid, rand_gnt, e_gnt, rand_data, m_data,
                     busy, e_busy, rc_act, rc_exp);
        end
    endtask

    // One service: idle cycle, sample, feed word MSB pair first, wait for pulse.
    task automatic serve(input string nm, input logic [3:0] mask, input logic [7:0] w,
                         input logic [3:0] gnt, input logic [7:0] data, input int lat);
        int n;
        cycle(4'b0, 2'b00, 1'b0);
        cycle(mask, 2'b00, 1'b0);
        n = 0;
        for (int j = 0; j < HALF; j++) begin
            cycle(mask, w[7-2*j -: 2], 1'b0);
            n++;
        end
        for (int t = 0; t < 16 && !rand_valid; t++) begin
            cycle(mask, 2'b00, 1'b0);
            n++;
        end
        chk({nm, "_valid"}, 32'(rand_valid), 32'd1);
        chk({nm, "_gnt"},   32'(rand_gnt),   32'(gnt));
        chk({nm, "_data"},  32'(rand_data),  32'(data));
        chk({nm, "_lat"},   32'(n),          32'(lat));
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] word;
        logic [3:0] gnt;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t       tbl[7];
    logic [3:0] fair_seq[8];
    logic [3:0] r_req;
    int         nsv;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, REJ ? 8'h9F : 8'hFF, 4'b0001, REJ ? 8'h9F : 8'hFF, DLV};
        tbl[1] = '{4'b0100, 8'h5A, 4'b0100, 8'h5A, DLV};
        tbl[2] = '{4'b1000, 8'h00, 4'b1000, 8'h00, DLV};
        tbl[3] = '{4'b0010, 8'h93, 4'b0010, 8'h93, DLV};
        tbl[4] = '{4'b1111, 8'h81, 4'b0100, 8'h81, DLV};  // ptr=1: search starts at 2
        tbl[5] = '{4'b1001, 8'h3C, 4'b1000, 8'h3C, DLV};  // ptr=2: search starts at 3
        tbl[6] = '{4'b1011, 8'h7E, 4'b0001, 8'h7E, DLV};  // ptr=3: wraps to 0
        for (int i = 0; i < 8; i++) fair_seq[i] = 4'(1) << (i % 4);
        m_cyc = 0; m_act = 1'b0;

        // Reset state
        cycle(4'b0, 2'b00, 1'b1);
        cycle(4'b0, 2'b00, 1'b1);
        chk("rst_valid", 32'(rand_valid), 32'd0);
        chk("rst_gnt",   32'(rand_gnt),   32'd0);
        chk("rst_data",  32'(rand_data),  32'd0);
        chk("rst_busy",  32'(busy),       32'd0);

        // Table of single services
        for (int i = 0; i < 7; i++)
            serve($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].word, tbl[i].gnt, tbl[i].data, tbl[i].lat);

        // Fairness: all requesters held high
        cycle(4'b0, 2'b00, 1'b1);
        nsv = 0;
        for (int t = 0; t < 120 && nsv < 8; t++) begin
            cycle(4'b1111, 2'b00, 1'b0);
            if (rand_valid) begin
                chk($sformatf("fair%0d", nsv), 32'(rand_gnt), 32'(fair_seq[nsv]));
                nsv++;
            end
        end
        chk("fair_count", 32'(nsv), 32'd8);

        // Withdrawal in FILL leaves ptr at 1
        cycle(4'b0, 2'b00, 1'b1);
        serve("wd_pre0", 4'b0001, 8'h11, 4'b0001, 8'h11, DLV);
        serve("wd_pre1", 4'b0010, 8'h22, 4'b0010, 8'h22, DLV);
        cycle(4'b0, 2'b00, 1'b0);
        cycle(4'b0100, 2'b00, 1'b0);
        cycle(4'b0100, 2'b01, 1'b0);
        cycle(4'b0000, 2'b10, 1'b0);
        chk("wd_busy",  32'(busy),       32'd0);
        chk("wd_valid", 32'(rand_valid), 32'd0);
        serve("wd_next", 4'b1100, 8'h12, 4'b0100, 8'h12, DLV);

        // Reset during FILL
        cycle(4'b0, 2'b00, 1'b0);
        cycle(4'b1000, 2'b00, 1'b0);
        cycle(4'b1000, 2'b11, 1'b0);
        cycle(4'b1000, 2'b10, 1'b0);
        cycle(4'b1000, 2'b01, 1'b1);
        chk("rstf_busy",  32'(busy),       32'd0);
        chk("rstf_valid", 32'(rand_valid), 32'd0);
        chk("rstf_data",  32'(rand_data),  32'd0);
        serve("rstf_next", 4'b1111, 8'h44, 4'b0001, 8'h44, DLV);

`ifdef RAND_REJECT_EN
        // Rejection: 0xFF refused, then 0x00 accepted 11 cycles after sampling
        cycle(4'b0, 2'b00, 1'b1);
        cycle(4'b0001, 2'b00, 1'b0);
        nsv = 0;
        for (int j = 0; j < HALF; j++) begin cycle(4'b0001, 2'b11, 1'b0); nsv++; end
        for (int t = 0; t < 20 && !rand_valid; t++) begin cycle(4'b0001, 2'b00, 1'b0); nsv++; end
        chk("rej_lat",  32'(nsv),        32'd11);
        chk("rej_data", 32'(rand_data),  32'd0);
        chk("rej_cnt",  32'(reject_cnt), 32'd1);

        // Saturation of reject_cnt
        cycle(4'b0, 2'b00, 1'b0);
        for (int t = 0; t < 1320; t++) cycle(4'b0001, 2'b11, 1'b0);
        chk("sat_cnt",  32'(reject_cnt), 32'd255);
        chk("sat_busy", 32'(busy),       32'd1);
        for (int t = 0; t < 20 && !rand_valid; t++) cycle(4'b0001, 2'b00, 1'b0);
        chk("sat_valid", 32'(rand_valid), 32'd1);
        chk("sat_cnt2",  32'(reject_cnt), 32'd255);
`endif

        // Randomised traffic against the model
        r_req = 4'b0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 5) == 0) r_req = 4'($urandom);
            cycle(r_req, 2'($urandom), $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
